clkdiv_multi: RTL and testbench

Parametrised multi-channel clock divider replacing the fixed 50→4 divider. Each channel derives a near-50%-duty divided clock and a single-cycle tick strobe from `clk50`, with a per-channel runtime-programmable divisor and enable. Feeds sample-rate, display-refresh and LED-animation timing in the audio visualiser.

---
 rtl/clkdiv_multi.sv | 119 +++++++++++
 tb/tb_clkdiv_multi.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider: per-channel divided clock, tick strobe and enable.
// Define CLKDIV_GLITCHFREE_EN to defer divisor updates to the end of the running period.
module clkdiv_multi #(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned DEFAULT_DIV = 12500000,
    parameter int unsigned SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk50,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                div_wvalid,
    output logic                div_wready,
    input  logic [SEL_W-1:0]    div_wsel,
    input  logic [CNT_W-1:0]    div_wdata,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] div_pending
);

    localparam logic [CNT_W-1:0] RstDiv = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MinDiv = CNT_W'(2);

    // High time is ceil(div/2) so odd divisors lean one cycle towards high.
    function automatic logic [CNT_W-1:0] half_up(input logic [CNT_W-1:0] d);
        return d - (d >> 1);
    endfunction

    logic             wready_q;
    logic [CNT_W-1:0] wdiv;

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) wready_q <= 1'b0;
        else     wready_q <= 1'b1;
    end

    assign div_wready = wready_q;
    assign wdiv       = (div_wdata < MinDiv) ? MinDiv : div_wdata;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [CNT_W-1:0] div_q;
        logic [CNT_W-1:0] hi_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_nxt;
        logic             clk_q;
        logic             tick_q;
        logic             wr;
        logic             last;

        assign wr      = div_wvalid && wready_q && (div_wsel == SEL_W'(c));
        assign last    = (cnt_q == div_q - CNT_W'(1));
        assign cnt_nxt = last ? '0 : cnt_q + CNT_W'(1);

`ifdef CLKDIV_GLITCHFREE_EN
        logic [CNT_W-1:0] pdiv_q;
        logic             pend_q;

        always_ff @(posedge clk50 or posedge rst) begin
            if (rst) begin
                div_q  <= RstDiv;
                hi_q   <= half_up(RstDiv);
                cnt_q  <= RstDiv - CNT_W'(1);
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                pdiv_q <= RstDiv;
                pend_q <= 1'b0;
            end else begin
                if (en[c]) begin
                    cnt_q  <= cnt_nxt;
                    clk_q  <= (cnt_nxt < hi_q);
                    tick_q <= (cnt_nxt == '0);
                end else begin
                    tick_q <= 1'b0;
                end
                // The wrap edge already restarts at cnt=0 with clk high; only swap the divisor.
                if (en[c] && last && pend_q) begin
                    div_q  <= pdiv_q;
                    hi_q   <= half_up(pdiv_q);
                    pend_q <= 1'b0;
                end
                if (wr) begin
                    pdiv_q <= wdiv;
                    pend_q <= 1'b1;
                end
            end
        end

        assign div_pending[c] = pend_q;
`else
        always_ff @(posedge clk50 or posedge rst) begin
            if (rst) begin
                div_q  <= RstDiv;
                hi_q   <= half_up(RstDiv);
                cnt_q  <= RstDiv - CNT_W'(1);
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (wr) begin
                // Park the counter at div-1 so the next enabled edge starts a fresh period.
                div_q  <= wdiv;
                hi_q   <= half_up(wdiv);
                cnt_q  <= wdiv - CNT_W'(1);
                tick_q <= 1'b0;
            end else if (en[c]) begin
                cnt_q  <= cnt_nxt;
                clk_q  <= (cnt_nxt < hi_q);
                tick_q <= (cnt_nxt == '0);
            end else begin
                tick_q <= 1'b0;
            end
        end

        assign div_pending[c] = 1'b0;
`endif

        assign clk_out[c] = clk_q;
        assign tick[c]    = tick_q;
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed self-checking bench for clkdiv_multi with three channels and a divisor of 4.
// Expectations follow CLKDIV_GLITCHFREE_EN when it is defined for the build.
module tb_clkdiv_multi;

    logic       clk50 = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] en = 3'b000;
    logic       div_wvalid = 1'b0;
    logic       div_wready;
    logic [1:0] div_wsel = 2'd0;
    logic [7:0] div_wdata = 8'd0;
    logic [2:0] clk_out;
    logic [2:0] tick;
    logic [2:0] div_pending;

    int checks = 0;
    int errors = 0;

    clkdiv_multi #(
        .CHANNELS   (3),
        .CNT_W      (8),
        .DEFAULT_DIV(4)
    ) dut (
        .clk50      (clk50),
        .rst        (rst),
        .en         (en),
        .div_wvalid (div_wvalid),
        .div_wready (div_wready),
        .div_wsel   (div_wsel),
        .div_wdata  (div_wdata),
        .clk_out    (clk_out),
        .tick       (tick),
        .div_pending(div_pending)
    );

    always #5 clk50 = ~clk50;

    task automatic write_div(input logic [1:0] sel, input logic [7:0] data);
        @(negedge clk50);
        div_wvalid = 1'b1;
        div_wsel   = sel;
        div_wdata  = data;
        @(negedge clk50);
        div_wvalid = 1'b0;
    endtask

    task automatic wait_tick(input int ch, output bit found);
        found = 1'b0;
        for (int i = 0; i < 32 && !found; i++) begin
            @(negedge clk50);
            if (tick[ch]) found = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic [9:0] act;
        #2;
        act = {clk_out, tick, div_pending, div_wready};
        checks++;
        if (act !== 10'b0) begin
            errors++;
            $display("FAIL reset_initial: got %b, expected %b", act, 10'b0);
        end
        @(negedge clk50);
        act = {clk_out, tick, div_pending, div_wready};
        checks++;
        if (act !== 10'b0) begin
            errors++;
            $display("FAIL reset_held_edge: got %b, expected %b", act, 10'b0);
        end
    endtask

    task automatic test_default;
        logic [6:0] act;
        logic [6:0] exp;
        logic       ec;
        logic       et;
        rst = 1'b0;
        en  = 3'b111;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk50);
            ec  = (i % 4) < 2;
            et  = (i % 4) == 0;
            exp = {1'b1, {3{et}}, {3{ec}}};
            act = {div_wready, tick, clk_out};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL default_cycle%0d {wready,tick,clk}: got %b, expected %b", i, act, exp);
            end
        end
    endtask

    task automatic test_div5;
        bit         found;
        logic [1:0] act;
        logic [1:0] exp;
        write_div(2'd1, 8'd5);
        wait_tick(1, found);
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL div5_ch1_tick_timeout: got %b, expected 1", found);
        end
        for (int i = 0; i < 10; i++) begin
            exp = {1'((i % 5) == 0), 1'((i % 5) < 3)};
            act = {tick[1], clk_out[1]};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL div5_ch1_cycle%0d {tick,clk}: got %b, expected %b", i, act, exp);
            end
            @(negedge clk50);
        end
        wait_tick(0, found);
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL div5_ch0_tick_timeout: got %b, expected 1", found);
        end
        for (int i = 0; i < 8; i++) begin
            exp = {1'((i % 4) == 0), 1'((i % 4) < 2)};
            act = {tick[0], clk_out[0]};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL div5_ch0_cycle%0d {tick,clk}: got %b, expected %b", i, act, exp);
            end
            @(negedge clk50);
        end
    endtask

    task automatic test_clamp;
        bit         found;
        logic [1:0] act;
        logic [1:0] exp;
        write_div(2'd0, 8'd0);
        write_div(2'd1, 8'd1);
        for (int ch = 0; ch < 2; ch++) begin
            wait_tick(ch, found);
            checks++;
            if (found !== 1'b1) begin
                errors++;
                $display("FAIL clamp_ch%0d_tick_timeout: got %b, expected 1", ch, found);
            end
            for (int i = 0; i < 6; i++) begin
                exp = {2{1'((i % 2) == 0)}};
                act = {tick[ch], clk_out[ch]};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL clamp_ch%0d_cycle%0d {tick,clk}: got %b, expected %b",
                             ch, i, act, exp);
                end
                @(negedge clk50);
            end
        end
    endtask

    task automatic test_bad_sel;
        bit         found;
        logic       c1;
        logic       e0;
        logic       e1;
        logic [6:0] act;
        logic [6:0] exp;
        wait_tick(0, found);
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL badsel_tick_timeout: got %b, expected 1", found);
        end
        c1         = clk_out[1];
        div_wvalid = 1'b1;
        div_wsel   = 2'd3;
        div_wdata  = 8'd7;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk50);
            if (i == 1) div_wvalid = 1'b0;
            e0  = (i % 2) == 0;
            e1  = c1 ^ i[0];
            exp = {3'b000, e1, e0, e1, e0};
            act = {div_pending, tick[1:0], clk_out[1:0]};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL badsel_cycle%0d {pend,tick,clk}: got %b, expected %b", i, act, exp);
            end
        end
    endtask

    task automatic test_async_reset;
        bit         found;
        logic [9:0] act;
        write_div(2'd0, 8'd6);
        wait_tick(0, found);
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL arst_tick_timeout: got %b, expected 1", found);
        end
        @(negedge clk50);
        @(negedge clk50);
        checks++;
        if (clk_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre_high: got %b, expected 1", clk_out[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        act = {clk_out, tick, div_pending, div_wready};
        checks++;
        if (act !== 10'b0) begin
            errors++;
            $display("FAIL arst_immediate: got %b, expected %b", act, 10'b0);
        end
        @(negedge clk50);
        act = {clk_out, tick, div_pending, div_wready};
        checks++;
        if (act !== 10'b0) begin
            errors++;
            $display("FAIL arst_held: got %b, expected %b", act, 10'b0);
        end
        rst = 1'b0;
    endtask

    task automatic test_enable;
        logic [3:0] tbl [12];
        logic [5:0] act;
        logic [5:0] exp;
        // Each entry is {tick1, clk1, tick0, clk0}; channel 2 mirrors channel 1.
        tbl = '{4'b1111, 4'b0101, 4'b0000, 4'b0000, 4'b1111, 4'b0101,
                4'b0001, 4'b0001, 4'b1101, 4'b0100, 4'b0000, 4'b0011};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk50);
            exp = {tbl[i][3:2], tbl[i]};
            act = {tick[2], clk_out[2], tick[1], clk_out[1], tick[0], clk_out[0]};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL enable_cycle%0d {t2,c2,t1,c1,t0,c0}: got %b, expected %b",
                         i, act, exp);
            end
            if (i == 4) en = 3'b110;
            if (i == 7) en = 3'b111;
        end
    endtask

    task automatic test_glitchfree;
        logic [2:0] tbl [11];
        logic [4:0] act;
        logic [4:0] exp;
        // Each entry is {pending0, tick0, clk0} for the cycles after the write edge.
`ifdef CLKDIV_GLITCHFREE_EN
        tbl = '{3'b100, 3'b100, 3'b011, 3'b001, 3'b001, 3'b001,
                3'b000, 3'b000, 3'b000, 3'b000, 3'b011};
`else
        tbl = '{3'b001, 3'b011, 3'b001, 3'b001, 3'b001, 3'b000,
                3'b000, 3'b000, 3'b000, 3'b011, 3'b001};
`endif
        @(negedge clk50);
        div_wvalid = 1'b1;
        div_wsel   = 2'd0;
        div_wdata  = 8'd8;
        for (int s = 0; s < 11; s++) begin
            @(negedge clk50);
            if (s == 0) div_wvalid = 1'b0;
            exp = {2'b00, tbl[s]};
            act = {div_pending, tick[0], clk_out[0]};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL div8_cycle%0d {pend,tick0,clk0}: got %b, expected %b",
                         s + 1, act, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_div5();
        test_clamp();
        test_bad_sel();
        test_async_reset();
        test_enable();
        test_glitchfree();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
